// File: rtl/add_drv_if.sv
// Operand request and result response channels between a sequencer (master) and add_drv (slave).
interface add_drv_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] out_sum;
    logic       out_mismatch;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_mismatch
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_mismatch
    );
endinterface

// File: rtl/add_drv.sv
// Request-side driver for a registered 4-bit adder: issues one operand pair, waits LAT edges,
// captures the adder sum and returns it with a self-check against the locally computed sum.
module add_drv #(
    parameter int unsigned LAT   = 1,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    add_drv_if.slave         drv,
    output logic [3:0]       a,
    output logic [3:0]       b,
    input  logic [4:0]       sum,
    output logic [ERR_W-1:0] err_cnt
);
    localparam int unsigned      CNT_W    = (LAT == 0) ? 1 : $clog2(LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       a_q, a_d;
    logic [3:0]       b_q, b_d;
    logic [4:0]       exp_q, exp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [4:0]       out_sum_q, out_sum_d;
    logic             out_mismatch_q, out_mismatch_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            exp_q          <= '0;
            cnt_q          <= '0;
            out_valid_q    <= 1'b0;
            out_sum_q      <= '0;
            out_mismatch_q <= 1'b0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            exp_q          <= exp_d;
            cnt_q          <= cnt_d;
            out_valid_q    <= out_valid_d;
            out_sum_q      <= out_sum_d;
            out_mismatch_q <= out_mismatch_d;
            err_cnt_q      <= err_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        exp_d          = exp_q;
        cnt_d          = cnt_q;
        out_valid_d    = out_valid_q;
        out_sum_d      = out_sum_q;
        out_mismatch_d = out_mismatch_q;
        err_cnt_d      = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (drv.in_valid) begin
                    a_d     = drv.in_a;
                    b_d     = drv.in_b;
                    exp_d   = {1'b0, drv.in_a} + {1'b0, drv.in_b};
                    cnt_d   = '0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // cnt counts edges since operands were driven; the sum is valid once it reaches LAT
                if (cnt_q == CNT_LAST) begin
                    out_sum_d      = sum;
                    out_mismatch_d = (sum != exp_q);
                    out_valid_d    = 1'b1;
                    state_d        = RESP;
                    if ((sum != exp_q) && (err_cnt_q != '1)) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (drv.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drv.in_ready     = (state_q == IDLE);
    assign drv.out_valid    = out_valid_q;
    assign drv.out_sum      = out_sum_q;
    assign drv.out_mismatch = out_mismatch_q;
    assign a                = a_q;
    assign b                = b_q;
    assign err_cnt          = err_cnt_q;
endmodule
